// File: rtl/bram_request_port_if.sv
// Request/response/BRAM bus bundle for bram_request_port.
// slave = the controller; master = load/store unit plus the BRAM port.
interface bram_request_port_if #(
    parameter int unsigned LINES = 4096,
    parameter int unsigned XLEN  = 32
);
    localparam int unsigned AW = $clog2(LINES);

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_err;
    logic              err_pulse;

    logic [AW-1:0]     bram_addr;
    logic              bram_en;
    logic [XLEN/8-1:0] bram_be;
    logic [XLEN-1:0]   bram_data_in;
    logic [XLEN-1:0]   bram_data_out;

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_data,
        input  rsp_ready, bram_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, err_pulse,
        output bram_addr, bram_en, bram_be, bram_data_in
    );

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_data,
        output rsp_ready, bram_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, err_pulse,
        input  bram_addr, bram_en, bram_be, bram_data_in
    );
endinterface

// File: rtl/bram_request_port.sv
// Load/store requester for one byte-enable BRAM port (1-cycle read latency).
// Define RANGE_CHECK_EN to flag addresses beyond LINES words as errors.
module bram_request_port #(
    parameter int unsigned LINES     = 4096,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_request_port_if.slave    bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = $clog2(LINES);
    localparam int unsigned PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(RSP_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    logic [1:0]      off;
    logic            misaligned, range_err, legal, accept;
    logic [3:0]      be_raw;

    logic            ld_v, ld_err, ld_uns, err_q;
    logic [1:0]      ld_off, ld_size;
    logic [XLEN-1:0] shifted, ld_word;

    logic [XLEN-1:0] mem_data [RSP_DEPTH];
    logic            mem_err  [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, outstanding;
    logic            push, pop, rsp_valid_i;

    assign off = bus.req_addr[1:0];

    always_comb begin
        misaligned = 1'b0;
        be_raw     = 4'hF;
        case (bus.req_size)
            2'd0: begin misaligned = 1'b0;       be_raw = 4'b0001 << off; end
            2'd1: begin misaligned = off[0];     be_raw = 4'b0011 << off; end
            2'd2: begin misaligned = (off != 2'd0); be_raw = 4'hF;       end
            default: misaligned = 1'b1;
        endcase
    end

`ifdef RANGE_CHECK_EN
    assign range_err = |bus.req_addr[31:AW+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];
    assign range_err      = 1'b0;
`endif

    assign legal  = !misaligned && !range_err;
    assign accept = bus.req_valid && bus.req_ready;

    assign bus.bram_en   = accept && legal;
    assign bus.bram_be   = (bus.bram_en && bus.req_we) ? be_raw : '0;
    assign bus.bram_addr = bus.req_addr[AW+1:2];

    always_comb begin
        bus.bram_data_in = bus.req_data;
        case (bus.req_size)
            2'd0:    bus.bram_data_in = {4{bus.req_data[7:0]}};
            2'd1:    bus.bram_data_in = {2{bus.req_data[15:0]}};
            default: bus.bram_data_in = bus.req_data;
        endcase
    end

    // Load attributes ride alongside the BRAM read for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_v    <= 1'b0;
            ld_err  <= 1'b0;
            ld_uns  <= 1'b0;
            ld_off  <= '0;
            ld_size <= '0;
            err_q   <= 1'b0;
        end else begin
            ld_v    <= accept && !bus.req_we;
            ld_err  <= !legal;
            ld_uns  <= bus.req_unsigned;
            ld_off  <= off;
            ld_size <= bus.req_size;
            err_q   <= accept && !legal;
        end
    end

    assign shifted = bus.bram_data_out >> {ld_off, 3'b000};

    always_comb begin
        ld_word = shifted;
        case (ld_size)
            2'd0:    ld_word = {{24{!ld_uns && shifted[7]}},  shifted[7:0]};
            2'd1:    ld_word = {{16{!ld_uns && shifted[15]}}, shifted[15:0]};
            default: ld_word = shifted;
        endcase
        if (ld_err) ld_word = '0;
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rsp_valid_i = (count != '0);
    assign push        = ld_v;
    assign pop         = rsp_valid_i && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= ld_word;
                mem_err[wr_ptr]  <= ld_err;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A pop this cycle frees a slot for a request accepted in the same cycle.
    assign outstanding   = count + CW'(ld_v);
    assign bus.req_ready = rst_n && ((outstanding - CW'(pop)) < DEPTH_C);

    assign bus.rsp_valid = rsp_valid_i;
    assign bus.rsp_data  = rsp_valid_i ? mem_data[rd_ptr] : '0;
    assign bus.rsp_err   = rsp_valid_i ? mem_err[rd_ptr]  : 1'b0;
    assign bus.err_pulse = err_q;
endmodule

// File: tb/tb_bram_request_port.sv
// Directed self-checking bench for bram_request_port with a behavioural BRAM.
module tb_bram_request_port;
    localparam int unsigned LINES     = 4096;
    localparam int unsigned RSP_DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bram_request_port_if #(.LINES(LINES), .XLEN(32)) bus ();

    bram_request_port #(.LINES(LINES), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [LINES];

    always @(posedge clk) begin
        if (bus.bram_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.bram_be[i]) mem[bus.bram_addr][8*i +: 8] <= bus.bram_data_in[8*i +: 8];
            bus.bram_data_out <= mem[bus.bram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] data);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_data     = data;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fire();
        cyc();
        bus.req_valid = 1'b0;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        drive(1'b1, addr, size, 1'b0, data);
        #1;
        fire();
    endtask

    // Load with rsp_ready held high: response expected exactly two cycles after accept.
    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] exp, input logic exp_err);
        drive(1'b0, addr, size, uns, 32'h0);
        #1;
        chk({tag, "_en"}, {31'b0, bus.bram_en}, {31'b0, !exp_err});
        fire();
        chk({tag, "_n1_valid"}, {31'b0, bus.rsp_valid}, 32'h0);
        chk({tag, "_n1_errp"}, {31'b0, bus.err_pulse}, {31'b0, exp_err});
        cyc(); #1;
        chk({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'h1);
        chk({tag, "_data"}, bus.rsp_data, exp);
        chk({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
        cyc(); #1;
        chk({tag, "_drain"}, {31'b0, bus.rsp_valid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_size = '0;
        bus.req_unsigned = 1'b0; bus.req_data = '0; bus.rsp_ready = 1'b1;

        @(negedge clk); @(negedge clk); #1;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_err",   {31'b0, bus.rsp_err},   32'h0);
        chk("rst_rsp_data",  bus.rsp_data,           32'h0);
        chk("rst_err_pulse", {31'b0, bus.err_pulse}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        drive(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF); #1;
        chk("sw_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("sw_en",    {31'b0, bus.bram_en},   32'h1);
        chk("sw_be",    {28'b0, bus.bram_be},   32'hF);
        chk("sw_addr",  {20'b0, bus.bram_addr}, 32'h4);
        chk("sw_din",   bus.bram_data_in,       32'hDEADBEEF);
        fire();
        chk("sw_no_rsp",  {31'b0, bus.rsp_valid}, 32'h0);
        chk("sw_no_errp", {31'b0, bus.err_pulse}, 32'h0);

        drive(1'b1, 32'h13, 2'd0, 1'b0, 32'h000000A5); #1;
        chk("sb_be",  {28'b0, bus.bram_be}, 32'h8);
        chk("sb_din", bus.bram_data_in,     32'hA5A5A5A5);
        fire();

        load_chk("lb13",  32'h13, 2'd0, 1'b0, 32'hFFFFFFA5, 1'b0);
        load_chk("lbu13", 32'h13, 2'd0, 1'b1, 32'h000000A5, 1'b0);

        drive(1'b1, 32'h12, 2'd1, 1'b0, 32'h0000BEEF); #1;
        chk("sh_be",  {28'b0, bus.bram_be}, 32'hC);
        chk("sh_din", bus.bram_data_in,     32'hBEEFBEEF);
        fire();

        store(32'h10, 2'd2, 32'h80011234);
        load_chk("lh12",  32'h12, 2'd1, 1'b0, 32'hFFFF8001, 1'b0);
        load_chk("lhu12", 32'h12, 2'd1, 1'b1, 32'h00008001, 1'b0);
        load_chk("lh10",  32'h10, 2'd1, 1'b0, 32'h00001234, 1'b0);
        load_chk("lbu11", 32'h11, 2'd0, 1'b1, 32'h00000012, 1'b0);

        load_chk("lw06_err", 32'h06, 2'd2, 1'b0, 32'h0, 1'b1);
        load_chk("sz3_err",  32'h10, 2'd3, 1'b0, 32'h0, 1'b1);

        drive(1'b1, 32'h05, 2'd1, 1'b0, 32'h1234); #1;
        chk("sh05_en", {31'b0, bus.bram_en}, 32'h0);
        fire();
        chk("sh05_errp", {31'b0, bus.err_pulse}, 32'h1);
        cyc(); #1;
        chk("sh05_no_rsp", {31'b0, bus.rsp_valid}, 32'h0);
        chk("sh05_errp_1cyc", {31'b0, bus.err_pulse}, 32'h0);
        load_chk("lw10_intact", 32'h10, 2'd2, 1'b0, 32'h80011234, 1'b0);

        store(32'h20, 2'd2, 32'h11111111);
        store(32'h24, 2'd2, 32'h22222222);
        store(32'h28, 2'd2, 32'h33333333);

        // Back-to-back loads, consumer always ready.
        drive(1'b0, 32'h20, 2'd2, 1'b0, 32'h0); #1;
        cyc();
        drive(1'b0, 32'h24, 2'd2, 1'b0, 32'h0); #1;
        chk("b2b_ready", {31'b0, bus.req_ready}, 32'h1);
        fire();
        chk("b2b_r1_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("b2b_r1_data",  bus.rsp_data,           32'h11111111);
        cyc(); #1;
        chk("b2b_r2_data",  bus.rsp_data,           32'h22222222);
        cyc(); #1;
        chk("b2b_drain",    {31'b0, bus.rsp_valid}, 32'h0);

        // Credit limit: three loads against a stalled consumer.
        bus.rsp_ready = 1'b0;
        drive(1'b0, 32'h20, 2'd2, 1'b0, 32'h0); #1;
        cyc();
        drive(1'b0, 32'h24, 2'd2, 1'b0, 32'h0); #1;
        chk("full_ready2", {31'b0, bus.req_ready}, 32'h1);
        cyc();
        drive(1'b0, 32'h28, 2'd2, 1'b0, 32'h0); #1;
        chk("full_ready3", {31'b0, bus.req_ready}, 32'h0);
        cyc(); #1;
        chk("full_stall_ready", {31'b0, bus.req_ready}, 32'h0);
        chk("full_stall_valid", {31'b0, bus.rsp_valid}, 32'h1);
        chk("full_stall_data",  bus.rsp_data,           32'h11111111);
        bus.rsp_ready = 1'b1; #1;
        chk("full_pop_ready", {31'b0, bus.req_ready}, 32'h1);
        chk("full_r1_data",   bus.rsp_data,           32'h11111111);
        fire();
        chk("full_r2_data",   bus.rsp_data,           32'h22222222);
        cyc(); #1;
        chk("full_r3_valid",  {31'b0, bus.rsp_valid}, 32'h1);
        chk("full_r3_data",   bus.rsp_data,           32'h33333333);
        cyc(); #1;
        chk("full_drain",     {31'b0, bus.rsp_valid}, 32'h0);

        store(32'h0, 2'd2, 32'hCAFEF00D);
`ifdef RANGE_CHECK_EN
        load_chk("lw4000", 32'h4000, 2'd2, 1'b0, 32'h0, 1'b1);
`else
        load_chk("lw4000", 32'h4000, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
`endif

        // Reset while a load is in flight: nothing must emerge afterwards.
        bus.rsp_ready = 1'b0;
        drive(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0; #1;
        chk("midrst_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("midrst_ready", {31'b0, bus.req_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc(); #1;
        chk("postrst_valid", {31'b0, bus.rsp_valid}, 32'h0);
        chk("postrst_ready", {31'b0, bus.req_ready}, 32'h1);
        bus.rsp_ready = 1'b1;
        load_chk("postrst_lw", 32'h24, 2'd2, 1'b0, 32'h22222222, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
